// File: rtl/idli_pkg.sv
// Shared types for the idli core: slice/counter widths, ALU and compare
// opcodes, plus the ALU sequencing state and flag bundle.
package idli_pkg;

  // One 4b operand slice; a 16b word is carried as four slices.
  typedef logic [3:0] slice_t;

  // Slice index within a word, 0 = least significant.
  typedef logic [1:0] ctr_t;

  typedef enum logic [1:0] {
    ALU_OP_ADD = 2'd0,
    ALU_OP_AND = 2'd1,
    ALU_OP_OR  = 2'd2,
    ALU_OP_XOR = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    CMP_OP_EQ = 2'd0,
    CMP_OP_NE = 2'd1,
    CMP_OP_LT = 2'd2,
    CMP_OP_GE = 2'd3
  } cmp_op_t;

  // Slice-serial ALU sequencing: waiting for slice 0, or mid-word.
  typedef enum logic {
    ALU_IDLE = 1'b0,
    ALU_BUSY = 1'b1
  } alu_state_t;

  // Condition flags accumulated across the four slices of a word.
  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } alu_flags_t;

  localparam ctr_t CTR_FIRST = 2'd0;
  localparam ctr_t CTR_LAST  = 2'd3;

  // Turn a completed flag set into a predicate bit. The unsigned "less
  // than" is borrow, i.e. no carry out of a subtract.
  function automatic logic cmp_eval(input cmp_op_t op, input logic sign,
                                    input alu_flags_t f);
    logic lt;
    lt = sign ? (f.n ^ f.v) : !f.c;
    case (op)
      CMP_OP_EQ: cmp_eval = f.z;
      CMP_OP_NE: cmp_eval = !f.z;
      CMP_OP_LT: cmp_eval = lt;
      CMP_OP_GE: cmp_eval = !lt;
      default:   cmp_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/idli_alu_slice.sv
// Combinational 4b ALU slice: adder with carry in/out and overflow, or a
// bitwise logic op. Carry and overflow are forced low for logic ops so the
// caller can capture them unconditionally.
module idli_alu_slice
  import idli_pkg::*;
(
  input  slice_t  lhs,
  input  slice_t  rhs,
  input  logic    inv,
  input  alu_op_t op,
  input  logic    c_in,
  output slice_t  s,
  output logic    c_out,
  output logic    v
);

  slice_t     r;
  logic [4:0] sum;

  assign r   = inv ? ~rhs : rhs;
  assign sum = {1'b0, lhs} + {1'b0, r} + {4'd0, c_in};

  // Select the slice result and its carry/overflow by opcode.
  always_comb begin
    s     = sum[3:0];
    c_out = 1'b0;
    v     = 1'b0;
    case (op)
      ALU_OP_ADD: begin
        s     = sum[3:0];
        c_out = sum[4];
        v     = (lhs[3] == r[3]) && (sum[3] != lhs[3]);
      end
      ALU_OP_AND: s = lhs & r;
      ALU_OP_OR:  s = lhs | r;
      ALU_OP_XOR: s = lhs ^ r;
      default:    s = sum[3:0];
    endcase
  end

endmodule

// File: rtl/idli_ex_alu.sv
// Slice-serial ALU and compare unit. Accepts one 4b slice per cycle, LSB
// slice first, returns a registered result slice one cycle later, and on
// the final slice of a word emits a one-cycle predicate pulse.
module idli_ex_alu
  import idli_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_vld,
  input  ctr_t    i_ctr,
  input  alu_op_t i_alu_op,
  input  logic    i_alu_rhs_inv,
  input  cmp_op_t i_cmp_op,
  input  logic    i_cmp_sign,
  input  slice_t  i_lhs,
  input  slice_t  i_rhs,
  output logic    o_res_vld,
  output slice_t  o_res,
  output ctr_t    o_res_ctr,
  output logic    o_pred_vld,
  output logic    o_pred
);

  // Sequencing and per-word state.
  alu_state_t state_q, state_d;
  ctr_t       exp_ctr_q, exp_ctr_d;
  logic       carry_q, carry_d;
  alu_flags_t flags_q, flags_d;

  // Controls captured on slice 0 and held for the rest of the word.
  alu_op_t    op_q, op_d;
  logic       inv_q, inv_d;
  cmp_op_t    cmp_op_q, cmp_op_d;
  logic       cmp_sign_q, cmp_sign_d;

  // Registered outputs.
  logic       res_vld_q, res_vld_d;
  slice_t     res_q, res_d;
  ctr_t       res_ctr_q, res_ctr_d;
  logic       pred_vld_q, pred_vld_d;
  logic       pred_q, pred_d;

  // Slice classification for this cycle.
  logic       start;
  logic       cont;
  logic       accept;
  logic       last;

  // Controls and carry actually applied to the current slice.
  alu_op_t    eff_op;
  logic       eff_inv;
  cmp_op_t    eff_cmp_op;
  logic       eff_cmp_sign;
  logic       eff_c_in;

  slice_t     slice_s;
  logic       slice_c_out;
  logic       slice_v;

  idli_alu_slice u_slice (
    .lhs   (i_lhs),
    .rhs   (i_rhs),
    .inv   (eff_inv),
    .op    (eff_op),
    .c_in  (eff_c_in),
    .s     (slice_s),
    .c_out (slice_c_out),
    .v     (slice_v)
  );

  // A valid slice 0 always starts a word, even if it interrupts one in
  // flight; otherwise only the expected next slice of a busy word counts.
  always_comb begin
    start  = i_vld && (i_ctr == CTR_FIRST);
    cont   = i_vld && (state_q == ALU_BUSY) && (i_ctr == exp_ctr_q) && !start;
    accept = start || cont;
    last   = cont && (i_ctr == CTR_LAST);

    eff_op       = start ? i_alu_op      : op_q;
    eff_inv      = start ? i_alu_rhs_inv : inv_q;
    eff_cmp_op   = start ? i_cmp_op      : cmp_op_q;
    eff_cmp_sign = start ? i_cmp_sign    : cmp_sign_q;
    eff_c_in     = start ? i_alu_rhs_inv : carry_q;
  end

  // Next-state for sequencing, carry/flags, held controls and outputs.
  always_comb begin
    state_d    = state_q;
    exp_ctr_d  = exp_ctr_q;
    carry_d    = carry_q;
    flags_d    = flags_q;
    op_d       = op_q;
    inv_d      = inv_q;
    cmp_op_d   = cmp_op_q;
    cmp_sign_d = cmp_sign_q;
    res_vld_d  = 1'b0;
    res_d      = res_q;
    res_ctr_d  = res_ctr_q;
    pred_vld_d = 1'b0;
    pred_d     = pred_q;

    if (start) begin
      state_d    = ALU_BUSY;
      exp_ctr_d  = CTR_FIRST + 2'd1;
      op_d       = i_alu_op;
      inv_d      = i_alu_rhs_inv;
      cmp_op_d   = i_cmp_op;
      cmp_sign_d = i_cmp_sign;
    end else if (cont) begin
      if (last) begin
        state_d = ALU_IDLE;
      end else begin
        exp_ctr_d = i_ctr + 2'd1;
      end
    end else if (i_vld && (state_q == ALU_BUSY)) begin
      // Out-of-order slice: drop the word without a predicate.
      state_d = ALU_IDLE;
    end

    if (accept) begin
      carry_d   = slice_c_out;
      flags_d.z = start ? (slice_s == 4'd0) : (flags_q.z && (slice_s == 4'd0));
      if (last) begin
        flags_d.c = slice_c_out;
        flags_d.n = slice_s[3];
        flags_d.v = slice_v;
      end
      res_vld_d = 1'b1;
      res_d     = slice_s;
      res_ctr_d = i_ctr;
    end

    if (last) begin
      pred_vld_d = 1'b1;
      pred_d     = cmp_eval(eff_cmp_op, eff_cmp_sign, flags_d);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ALU_IDLE;
      exp_ctr_q  <= CTR_FIRST;
      carry_q    <= 1'b0;
      flags_q    <= '0;
      op_q       <= ALU_OP_ADD;
      inv_q      <= 1'b0;
      cmp_op_q   <= CMP_OP_EQ;
      cmp_sign_q <= 1'b0;
      res_vld_q  <= 1'b0;
      res_q      <= '0;
      res_ctr_q  <= '0;
      pred_vld_q <= 1'b0;
      pred_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_ctr_q  <= exp_ctr_d;
      carry_q    <= carry_d;
      flags_q    <= flags_d;
      op_q       <= op_d;
      inv_q      <= inv_d;
      cmp_op_q   <= cmp_op_d;
      cmp_sign_q <= cmp_sign_d;
      res_vld_q  <= res_vld_d;
      res_q      <= res_d;
      res_ctr_q  <= res_ctr_d;
      pred_vld_q <= pred_vld_d;
      pred_q     <= pred_d;
    end
  end

  assign o_res_vld  = res_vld_q;
  assign o_res      = res_q;
  assign o_res_ctr  = res_ctr_q;
  assign o_pred_vld = pred_vld_q;
  assign o_pred     = pred_q;

endmodule

// File: tb/tb_idli_ex_alu.sv
// Directed bench for idli_ex_alu: a table of full-word operations run
// back-to-back, then hand sequences for stall, abort and mid-op reset.
module tb_idli_ex_alu;
  import idli_pkg::*;

  logic    clk = 1'b0;
  logic    i_rst;
  logic    i_vld;
  ctr_t    i_ctr;
  alu_op_t i_alu_op;
  logic    i_alu_rhs_inv;
  cmp_op_t i_cmp_op;
  logic    i_cmp_sign;
  slice_t  i_lhs;
  slice_t  i_rhs;
  logic    o_res_vld;
  slice_t  o_res;
  ctr_t    o_res_ctr;
  logic    o_pred_vld;
  logic    o_pred;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  idli_ex_alu dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_vld         (i_vld),
    .i_ctr         (i_ctr),
    .i_alu_op      (i_alu_op),
    .i_alu_rhs_inv (i_alu_rhs_inv),
    .i_cmp_op      (i_cmp_op),
    .i_cmp_sign    (i_cmp_sign),
    .i_lhs         (i_lhs),
    .i_rhs         (i_rhs),
    .o_res_vld     (o_res_vld),
    .o_res         (o_res),
    .o_res_ctr     (o_res_ctr),
    .o_pred_vld    (o_pred_vld),
    .o_pred        (o_pred)
  );

  typedef struct {
    string       name;
    alu_op_t     op;
    logic        inv;
    cmp_op_t     cmp;
    logic        sign;
    logic [15:0] lhs;
    logic [15:0] rhs;
    logic [15:0] exp_res;
    logic        chk_pred;
    logic        exp_pred;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slice(input logic vld, input int k, input logic [15:0] lhs,
                           input logic [15:0] rhs, input alu_op_t op, input logic inv,
                           input cmp_op_t cmp, input logic sign);
    i_vld         = vld;
    i_ctr         = ctr_t'(k);
    i_lhs         = lhs[4*k +: 4];
    i_rhs         = rhs[4*k +: 4];
    i_alu_op      = op;
    i_alu_rhs_inv = inv;
    i_cmp_op      = cmp;
    i_cmp_sign    = sign;
  endtask

  task automatic run_op(input vec_t v);
    logic [15:0] got;
    got = '0;
    for (int k = 0; k < 4; k++) begin
      set_slice(1'b1, k, v.lhs, v.rhs, v.op, v.inv, v.cmp, v.sign);
      tick();
      chk({v.name, "_res_vld"}, 32'(o_res_vld), 32'd1);
      chk({v.name, "_res_ctr"}, 32'(o_res_ctr), 32'(k));
      chk({v.name, "_pred_vld"}, 32'(o_pred_vld), 32'(k == 3));
      got[4*k +: 4] = o_res;
    end
    chk({v.name, "_res"}, 32'(got), 32'(v.exp_res));
    if (v.chk_pred) chk({v.name, "_pred"}, 32'(o_pred), 32'(v.exp_pred));
    $display("op %-10s lhs=%04h rhs=%04h res=%04h pred=%0b", v.name, v.lhs, v.rhs, got, o_pred);
  endtask

  task automatic idle_inputs();
    i_vld = 1'b0; i_ctr = '0; i_lhs = '0; i_rhs = '0;
    i_alu_op = ALU_OP_ADD; i_alu_rhs_inv = 1'b0; i_cmp_op = CMP_OP_EQ; i_cmp_sign = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_res_vld"}, 32'(o_res_vld), 32'd0);
    chk({tag, "_res"}, 32'(o_res), 32'd0);
    chk({tag, "_res_ctr"}, 32'(o_res_ctr), 32'd0);
    chk({tag, "_pred_vld"}, 32'(o_pred_vld), 32'd0);
    chk({tag, "_pred"}, 32'(o_pred), 32'd0);
  endtask

  initial begin
    logic [15:0] got;
    vec_t v;

    vecs[0]  = '{"add",     ALU_OP_ADD, 1'b0, CMP_OP_EQ, 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0};
    vecs[1]  = '{"lt_s",    ALU_OP_ADD, 1'b1, CMP_OP_LT, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    vecs[2]  = '{"lt_u",    ALU_OP_ADD, 1'b1, CMP_OP_LT, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0};
    vecs[3]  = '{"eq_t",    ALU_OP_ADD, 1'b1, CMP_OP_EQ, 1'b0, 16'h5A5A, 16'h5A5A, 16'h0000, 1'b1, 1'b1};
    vecs[4]  = '{"eq_f",    ALU_OP_ADD, 1'b1, CMP_OP_EQ, 1'b0, 16'h5A5A, 16'h5A5B, 16'hFFFF, 1'b1, 1'b0};
    vecs[5]  = '{"xor_inv", ALU_OP_XOR, 1'b1, CMP_OP_EQ, 1'b0, 16'hF0F0, 16'hFF00, 16'hF00F, 1'b0, 1'b0};
    vecs[6]  = '{"ge_s",    ALU_OP_ADD, 1'b1, CMP_OP_GE, 1'b1, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b1};
    vecs[7]  = '{"ne_f",    ALU_OP_ADD, 1'b1, CMP_OP_NE, 1'b0, 16'h1111, 16'h1111, 16'h0000, 1'b1, 1'b0};
    vecs[8]  = '{"and",     ALU_OP_AND, 1'b0, CMP_OP_EQ, 1'b0, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0};
    vecs[9]  = '{"or",      ALU_OP_OR,  1'b0, CMP_OP_EQ, 1'b0, 16'hF0F0, 16'h0F01, 16'hFFF1, 1'b0, 1'b0};
    vecs[10] = '{"lt_u2",   ALU_OP_ADD, 1'b1, CMP_OP_LT, 1'b0, 16'h0001, 16'h0002, 16'hFFFF, 1'b1, 1'b1};
    vecs[11] = '{"ge_u",    ALU_OP_ADD, 1'b1, CMP_OP_GE, 1'b0, 16'h0001, 16'h0002, 16'hFFFF, 1'b1, 1'b0};

    // Reset values.
    idle_inputs();
    i_rst = 1'b1;
    tick();
    tick();
    chk_reset_outputs("por");
    i_rst = 1'b0;
    tick();
    chk("idle_res_vld", 32'(o_res_vld), 32'd0);

    // Table of words, issued back-to-back with no bubble.
    for (int i = 0; i < 12; i++) run_op(vecs[i]);

    // Idle cycle: valids drop, data outputs hold (last word ge_u: res slice F, pred 0).
    idle_inputs();
    tick();
    chk("hold_res_vld", 32'(o_res_vld), 32'd0);
    chk("hold_pred_vld", 32'(o_pred_vld), 32'd0);
    chk("hold_res", 32'(o_res), 32'hF);
    chk("hold_ctr", 32'(o_res_ctr), 32'd3);
    $display("seq hold res=%0h pred=%0b", o_res, o_pred);

    // Stall: 0x0FFF + 0x0001 with two dead cycles after slice 1; controls
    // driven as OR/inv during the stall and later slices must be ignored.
    got = '0;
    for (int k = 0; k < 2; k++) begin
      set_slice(1'b1, k, 16'h0FFF, 16'h0001, ALU_OP_ADD, 1'b0, CMP_OP_EQ, 1'b0);
      tick();
      chk("stall_vld", 32'(o_res_vld), 32'd1);
      got[4*k +: 4] = o_res;
    end
    for (int s = 0; s < 2; s++) begin
      set_slice(1'b0, 2, 16'h0FFF, 16'h0001, ALU_OP_OR, 1'b1, CMP_OP_LT, 1'b1);
      tick();
      chk("stall_gap_vld", 32'(o_res_vld), 32'd0);
    end
    for (int k = 2; k < 4; k++) begin
      set_slice(1'b1, k, 16'h0FFF, 16'h0001, ALU_OP_OR, 1'b1, CMP_OP_LT, 1'b1);
      tick();
      chk("stall_vld", 32'(o_res_vld), 32'd1);
      chk("stall_ctr", 32'(o_res_ctr), 32'(k));
      got[4*k +: 4] = o_res;
    end
    chk("stall_res", 32'(got), 32'h1000);
    chk("stall_pred_vld", 32'(o_pred_vld), 32'd1);
    $display("seq stall res=%04h", got);

    // Abort: slices 0,1,3 give no predicate; stray slices in IDLE are dropped.
    for (int k = 0; k < 2; k++) begin
      set_slice(1'b1, k, 16'h5A5A, 16'h5A5A, ALU_OP_ADD, 1'b1, CMP_OP_EQ, 1'b0);
      tick();
    end
    set_slice(1'b1, 3, 16'h5A5A, 16'h5A5A, ALU_OP_ADD, 1'b1, CMP_OP_EQ, 1'b0);
    tick();
    chk("abort_pred_vld", 32'(o_pred_vld), 32'd0);
    set_slice(1'b1, 2, 16'h5A5A, 16'h5A5A, ALU_OP_ADD, 1'b1, CMP_OP_EQ, 1'b0);
    tick();
    chk("stray2_res_vld", 32'(o_res_vld), 32'd0);
    set_slice(1'b1, 3, 16'h5A5A, 16'h5A5A, ALU_OP_ADD, 1'b1, CMP_OP_EQ, 1'b0);
    tick();
    chk("stray3_res_vld", 32'(o_res_vld), 32'd0);
    chk("stray3_pred_vld", 32'(o_pred_vld), 32'd0);
    $display("seq abort pred_vld=%0b res_vld=%0b", o_pred_vld, o_res_vld);

    // Mid-op reset after a word that left pred=1.
    run_op(vecs[3]);
    for (int k = 0; k < 2; k++) begin
      set_slice(1'b1, k, 16'h1234, 16'h1111, ALU_OP_ADD, 1'b0, CMP_OP_EQ, 1'b0);
      tick();
    end
    set_slice(1'b1, 2, 16'h1234, 16'h1111, ALU_OP_ADD, 1'b0, CMP_OP_EQ, 1'b0);
    i_rst = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    i_rst = 1'b0;
    $display("seq midrst res_vld=%0b pred=%0b", o_res_vld, o_pred);
    v = '{"post_add", ALU_OP_ADD, 1'b0, CMP_OP_EQ, 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0};
    run_op(v);
    v = '{"post_lt", ALU_OP_ADD, 1'b1, CMP_OP_LT, 1'b1, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b0};
    run_op(v);

    idle_inputs();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
